dp_result_sink: RTL

- Downstream consumer of the shift-add multiplier datapath.
- Watches the datapath's done flag and captures the 8-bit product once per completed operation, on the rising edge of done.
- Buffers products in a small first-word-fall-through FIFO and presents them to the next stage over a valid/ready handshake.
- Tracks a capture count and a sticky overflow flag.

---
 rtl/dp_result_sink.sv | 111 +++++++++++
 1 files changed

// File: rtl/dp_result_sink.sv
// Result sink: captures datapath products on rising dp_done into a FWFT FIFO and drains them over valid/ready.
// Optional running saturating sum on acc_sum when DP_RESULT_ACC_EN is defined.
module dp_result_sink #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8,
  parameter int ACC_W  = 12
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] dp_out,
  input  logic              dp_done,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
`ifdef DP_RESULT_ACC_EN
  output logic [ACC_W-1:0]  acc_sum,
`endif
  output logic              overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = AW + 1;

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [AW-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0]     wr_ptr_reg;
  logic [OW-1:0]     occ_reg, occ_next;
  logic [DATA_W-1:0] head_reg, head_next;
  logic [CNT_W-1:0]  count_reg;
  logic              done_q_reg;
  logic              overflow_reg;

  logic cap, pop, push, drop;

  assign empty     = (occ_reg == '0);
  assign full      = (occ_reg == OW'(DEPTH));
  assign out_valid = ~empty;
  assign out_data  = head_reg;
  assign count     = count_reg;
  assign overflow  = overflow_reg;

  assign cap  = dp_done & ~done_q_reg;
  assign pop  = out_valid & out_ready;
  // A full FIFO can still accept when the head leaves in the same cycle.
  assign push = cap & (~full | pop);
  assign drop = cap & full & ~pop;

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    if (pop) rd_ptr_next = rd_ptr_reg + AW'(1);

    occ_next = occ_reg;
    if (push && !pop)      occ_next = occ_reg + OW'(1);
    else if (pop && !push) occ_next = occ_reg - OW'(1);

    // Head register tracks the entry that will sit at rd_ptr after this edge,
    // bypassing the write when the incoming product becomes the only entry.
    head_next = '0;
    if (occ_next != '0) begin
      if (push && (wr_ptr_reg == rd_ptr_next)) head_next = dp_out;
      else                                     head_next = mem_reg[rd_ptr_next];
    end
  end

  // Storage is intentionally left out of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (!clr && push) mem_reg[wr_ptr_reg] <= dp_out;
  end

  always_ff @(posedge clk) begin
    done_q_reg <= dp_done;
    if (clr) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      occ_reg      <= '0;
      head_reg     <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      occ_reg    <= occ_next;
      head_reg   <= head_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
        count_reg  <= count_reg + CNT_W'(1);
      end
      if (drop) overflow_reg <= 1'b1;
    end
  end

`ifdef DP_RESULT_ACC_EN
  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W:0]   acc_wide;

  assign acc_wide = {1'b0, acc_reg} + (ACC_W + 1)'(dp_out);
  assign acc_sum  = acc_reg;

  always_ff @(posedge clk) begin
    if (clr) begin
      acc_reg <= '0;
    end else if (push) begin
      acc_reg <= acc_wide[ACC_W] ? {ACC_W{1'b1}} : acc_wide[ACC_W-1:0];
    end
  end
`endif

endmodule
